// File: rtl/divided_clock_counter_if.sv
// Control/result bundle for divided_clock_counter.
// The requester drives start/gate_cycles and receives the count result.
interface divided_clock_counter_if #(
    parameter int CNT_W  = 16,
    parameter int GATE_W = 16
);
    logic              start;
    logic [GATE_W-1:0] gate_cycles;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    modport master (
        output start, gate_cycles,
        input  busy, done, count, overflow
    );

    modport slave (
        input  start, gate_cycles,
        output busy, done, count, overflow
    );
endinterface

// File: rtl/divided_clock_counter.sv
// Counts rising edges of an asynchronous divided clock over a
// programmable window of system-clock cycles.
module divided_clock_counter #(
    parameter int CNT_W       = 16,
    parameter int GATE_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic sig_in,
    divided_clock_counter_if.slave ctl
);
    typedef enum logic {IDLE, COUNT} state_t;

    localparam logic [CNT_W-1:0]  CNT_ONE = 1;
    localparam logic [GATE_W-1:0] TMR_ONE = 1;

    state_t state;
    state_t state_nxt;

    logic [SYNC_STAGES-1:0] sync_q;
    logic s_d;
    logic rise;

    logic [GATE_W-1:0] timer;
    logic [CNT_W-1:0]  acc;
    logic [CNT_W-1:0]  acc_nxt;
    logic ovf;
    logic ovf_nxt;

    logic done_q;
    logic [CNT_W-1:0] count_q;
    logic overflow_q;

    logic launch;
    logic zero_req;
    logic last;

    // Flops reset high so a level already high at release is not an edge
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            s_d    <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_d    <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~s_d;

    always_comb begin
        acc_nxt = acc;
        ovf_nxt = ovf;
        if (rise) begin
            if (acc == '1) begin
                ovf_nxt = 1'b1;
            end else begin
                acc_nxt = acc + CNT_ONE;
            end
        end
    end

    assign launch   = (state == IDLE) && ctl.start
                      && (ctl.gate_cycles != '0);
    assign zero_req = (state == IDLE) && ctl.start
                      && (ctl.gate_cycles == '0);
    assign last     = (state == COUNT) && (timer == TMR_ONE);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (launch) state_nxt = COUNT;
            COUNT:   if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            timer      <= '0;
            acc        <= '0;
            ovf        <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (1'b1)
                launch: begin
                    timer <= ctl.gate_cycles;
                    acc   <= '0;
                    ovf   <= 1'b0;
                end
                zero_req: begin
                    count_q    <= '0;
                    overflow_q <= 1'b0;
                    done_q     <= 1'b1;
                end
                last: begin
                    acc        <= acc_nxt;
                    ovf        <= ovf_nxt;
                    timer      <= timer - TMR_ONE;
                    count_q    <= acc_nxt;
                    overflow_q <= ovf_nxt;
                    done_q     <= 1'b1;
                end
                default: begin
                    if (state == COUNT) begin
                        acc   <= acc_nxt;
                        ovf   <= ovf_nxt;
                        timer <= timer - TMR_ONE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        ctl.busy     = (state == COUNT);
        ctl.done     = done_q;
        ctl.count    = count_q;
        ctl.overflow = overflow_q;
    end
endmodule
